// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers EX results under the stall vector and
// extracts load data from the synchronous data SRAM read port for WB and ID forwarding.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [31:0] ex_pc,
  input  logic        ex_load,
  input  logic [2:0]  ex_ld_type,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic [31:0] ex_result,
  input  logic        ex_hi_we,
  input  logic        ex_lo_we,
  input  logic [31:0] ex_hi_wdata,
  input  logic [31:0] ex_lo_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] wb_pc,
  output logic        wb_rf_we,
  output logic [4:0]  wb_rf_waddr,
  output logic [31:0] wb_rf_wdata,
  output logic        wb_hi_we,
  output logic        wb_lo_we,
  output logic [31:0] wb_hi_wdata,
  output logic [31:0] wb_lo_wdata,
  output logic        mem_load_pending
);

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic [31:0] r_pc;
  logic        r_load;
  logic [2:0]  r_ld_type;
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_result;
  logic        r_hi_we;
  logic        r_lo_we;
  logic [31:0] r_hi_wdata;
  logic [31:0] r_lo_wdata;
  logic        r_cap_q;
  logic [31:0] r_rd_hold;
  logic        r_hold_v;

  logic        w_mem_stop;
  logic        w_wb_stop;
  logic [31:0] w_rdata_eff;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_mem_stop = stall[3];
  assign w_wb_stop  = stall[4];

  always_ff @(posedge clk) begin
    if (rst || (w_mem_stop && !w_wb_stop)) begin
      r_pc       <= '0;
      r_load     <= 1'b0;
      r_ld_type  <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_result   <= '0;
      r_hi_we    <= 1'b0;
      r_lo_we    <= 1'b0;
      r_hi_wdata <= '0;
      r_lo_wdata <= '0;
    end else if (!w_mem_stop) begin
      r_pc       <= ex_pc;
      r_load     <= ex_load;
      r_ld_type  <= ex_ld_type;
      r_rf_we    <= ex_rf_we;
      r_rf_waddr <= ex_rf_waddr;
      r_result   <= ex_result;
      r_hi_we    <= ex_hi_we;
      r_lo_we    <= ex_lo_we;
      r_hi_wdata <= ex_hi_wdata;
      r_lo_wdata <= ex_lo_wdata;
    end
  end

  // SRAM data is only valid the first cycle after capture; latch it if WB stalls then.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_q   <= 1'b0;
      r_rd_hold <= '0;
      r_hold_v  <= 1'b0;
    end else begin
      r_cap_q <= !w_mem_stop;
      if (!w_mem_stop || !w_wb_stop) begin
        r_hold_v <= 1'b0;
      end else if (r_cap_q) begin
        r_rd_hold <= data_sram_rdata;
        r_hold_v  <= 1'b1;
      end
    end
  end

  assign w_rdata_eff = r_hold_v ? r_rd_hold : data_sram_rdata;

  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    case (r_result[1:0])
      2'd0:    w_byte = w_rdata_eff[7:0];
      2'd1:    w_byte = w_rdata_eff[15:8];
      2'd2:    w_byte = w_rdata_eff[23:16];
      default: w_byte = w_rdata_eff[31:24];
    endcase
    w_half = r_result[1] ? w_rdata_eff[31:16] : w_rdata_eff[15:0];
  end

  always_comb begin
    w_load_data = w_rdata_eff;
    case (r_ld_type)
      LD_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  w_load_data = {24'h000000, w_byte};
      LD_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  w_load_data = {16'h0000, w_half};
      default: w_load_data = w_rdata_eff;
    endcase
  end

  assign wb_pc            = r_pc;
  assign wb_rf_we         = r_rf_we;
  assign wb_rf_waddr      = r_rf_waddr;
  assign wb_rf_wdata      = r_load ? w_load_data : r_result;
  assign wb_hi_we         = r_hi_we;
  assign wb_lo_we         = r_lo_we;
  assign wb_hi_wdata      = r_hi_wdata;
  assign wb_lo_wdata      = r_lo_wdata;
  assign mem_load_pending = r_load & r_rf_we;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the five-stage MIPS core, directly downstream of EX and upstream of WB. It registers EX results under the global stall vector and extracts load data from the synchronous data SRAM read port. The data extraction handles byte, halfword and word loads, both signed and unsigned. It then presents the write-back payload for the GPRs and hi/lo, and also drives the same payload as the MEM-to-ID forwarding source.

## Interface
Parameters: none.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  global stall vector; bit 3 = MEM input register, bit 4 = WB; 1 = Stop
- ex_pc  in  32  PC of EX instruction
- ex_load  in  1  instruction is a load (SRAM read issued this cycle by EX)
- ex_ld_type  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others treated as LW
- ex_rf_we  in  1  GPR write enable
- ex_rf_waddr  in  5  GPR destination
- ex_result  in  32  ALU result / load address
- ex_hi_we, ex_lo_we  in  1 each  hi/lo write enables
- ex_hi_wdata, ex_lo_wdata  in  32 each  hi/lo write data
- data_sram_rdata  in  32  SRAM read data, valid the cycle after EX presents the address
- wb_pc  out  32  registered PC
- wb_rf_we  out  1  GPR write enable
- wb_rf_waddr  out  5  GPR destination
- wb_rf_wdata  out  32  load data or ex_result
- wb_hi_we, wb_lo_we  out  1 each; wb_hi_wdata, wb_lo_wdata  out  32 each
- mem_load_pending  out  1  the held instruction is a load with rf_we=1 (for hazard logic in ID)

## Operation
- Input register (all ex_* fields), updated on posedge clk, priority order:
  - rst: clear to zero.
  - stall[3]=Stop and stall[4]=NoStop: load a bubble (all zero).
  - stall[3]=NoStop: capture ex_* fields.
  - otherwise: hold.
- Flag cap_q: set to 1 on the cycle a real capture occurs; 0 otherwise (reset, bubble, hold).
- Read-data hold register rd_hold[31:0] and flag hold_v:
  - When cap_q=1 and stall[4]=Stop: rd_hold <= data_sram_rdata, hold_v <= 1.
  - Any capture, bubble or rst: hold_v <= 0.
  - Effective data: rdata_eff = hold_v ? rd_hold : data_sram_rdata.
- Load extraction uses addr = result_r[1:0], little-endian:
  - LB / LBU: byte addr selected (0 → [7:0] … 3 → [31:24]), then sign- or zero-extended.
  - LH / LHU: addr[1]=0 → [15:0], addr[1]=1 → [31:16], then sign- or zero-extended. addr[0] is ignored; no exception is raised.
  - LW: rdata_eff unchanged; addr[1:0] ignored.
- wb_rf_wdata = load_r ? extracted : result_r.
- All wb_* outputs are combinational from the input register plus rdata_eff.
- mem_load_pending = load_r & rf_we_r.

## Timing
- Reset: every output is 0, hold_v=0, cap_q=0.
- Latency: an EX instruction appears on wb_* one cycle after capture. Load data is combinational from the SRAM on that cycle.
- Stalled load: if MEM holds a load for N>1 cycles, wb_rf_wdata stays constant for all N cycles and equals the SRAM data from the first cycle, even if data_sram_rdata changes afterwards.
- Bubble: all enables are 0, so no GPR or hi/lo write occurs.
- If stall[3] and stall[4] are both Stop, the register and hold state are frozen.
- rst asserted mid-stall clears the register and the hold state on the next edge.
- hi_we and lo_we may both be 1 (mult/div); both pass through unchanged alongside a simultaneous rf_we.

## Test plan
- LB sign extension: result=0x1000_0003, rdata=0x80FF_1234 → wb_rf_wdata=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- LH / LHU: result=0x...2, rdata=0x8001_7FFF → LH gives 0xFFFF_8001, LHU gives 0x0000_8001. With result=0x...0, LH gives 0x0000_7FFF.
- Load then stall[4]=Stop for 3 cycles:
  - rdata is 0xDEAD_BEEF on the first cycle, then 0x0.
  - Required: wb_rf_wdata=0xDEAD_BEEF on all 4 cycles, and mem_load_pending=1.
- Bubble insertion: stall=6'b001111 for one cycle → next cycle all wb_* enables are 0 and wb_pc=0.
- Non-load plus mult: rf_we=0, hi_we=lo_we=1, hi=0x1, lo=0x2 → wb_hi_wdata=0x1 and wb_lo_wdata=0x2 one cycle after capture. wb_rf_wdata equals ex_result.
- rst asserted while holding a stalled load → next cycle all outputs are 0 and hold_v=0.
